swd_host_engine: RTL and testbench
==================================

Name: swd_host_engine

Overview:
- SWD initiator (probe side) for the opposite end of the SW-DP wire protocol.
- Accepts one command at a time: either a DP/AP transfer or a raw bit sequence for line reset and dormant wake.
- Generates swclk, drives and releases swdio, samples the ACK and read data, and returns one response per command.
- Used by bench rigs and FPGA self-test tops that exercise the DP on-chip.

Parameters:
- CLK_DIV, 4: clk cycles per swclk half-period. Legal range is 1 to 255.
- IDLE_BITS, 2: number of low idle bits driven after every transfer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd_raw  in  1  1 = raw sequence, 0 = DP/AP transfer.
- cmd_apndp  in  1  request APnDP bit.
- cmd_rnw  in  1  request RnW bit.
- cmd_addr  in  2  request A[3:2].
- cmd_wdata  in  32  write data, or raw bits (sent LSB first).
- cmd_nbits  in  6  raw bit count minus one, giving 1 to 64 bits. Bits above 31 repeat cmd_wdata[31].
- rsp_valid  out  1  single-cycle response strobe.
- rsp_ack  out  3  ACK as received, with bit0 received first.
- rsp_rdata  out  32  read data.
- rsp_perr  out  1  read data parity mismatch.
- swclk  out  1  SWD clock.
- swdio_o  out  1  SWDIO output value.
- swdio_oe  out  1  SWDIO output enable.
- swdio_i  in  1  SWDIO pad input.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_ack=0, rsp_rdata=0, rsp_perr=0, swclk=0, swdio_o=1, swdio_oe=0.
- Reset is checked before everything else, including mid-transfer. A reset mid-transfer abandons the transfer, issues no response and releases the line immediately.
- cmd_ready is high in the IDLE state. A command is accepted when cmd_valid && cmd_ready, and all command fields are captured in that cycle.
- swclk timing:
  - Toggles every CLK_DIV clk cycles while the engine is busy, giving a period of 2*CLK_DIV cycles. It idles low.
  - The host updates swdio_o/oe when it generates a falling edge.
  - The host registers swdio_i in the clk cycle that generates a rising edge.
- Bit timing: each SWD bit occupies one swclk period. The first bit is driven one clk cycle after acceptance.
- State machine:
  - IDLE: accept a command. Go to RAW if cmd_raw=1, otherwise go to REQ.
  - REQ: drive 8 bits, LSB first: 1, APnDP, RnW, A2, A3, parity, 0, 1. Parity is the even-parity XOR of the four bits between start and parity.
  - TRN1: release the line (oe=0) for 1 bit.
  - ACK: sample 3 bits.
    - ACK=3'b001 with RnW=1: go to RDATA.
    - ACK=3'b001 with RnW=0: go to WTRN.
    - Any other ACK (WAIT 010, FAULT 100, or an invalid value): go to TRN2 and skip the data phase.
  - RDATA: sample 32 data bits and 1 parity bit. rsp_perr = (XOR of the data) != parity bit. Then go to TRN2.
  - TRN2: keep the line released for 1 bit, then go to TAIL.
  - WTRN: keep the line released for 1 bit, then go to WDATA.
  - WDATA: drive oe=1 with 32 data bits LSB first, then the parity bit. Then go to TAIL.
  - TAIL: drive oe=1, o=0 for IDLE_BITS bits. Then pulse rsp_valid, set swclk low and go to IDLE.
  - RAW: drive cmd_nbits+1 bits. Then pulse rsp_valid with rsp_ack=0 and go to IDLE. Raw sequences have no TAIL.
- Response fields: rsp_ack, rsp_rdata and rsp_perr hold their values until the next response. rsp_rdata=0 and rsp_perr=0 unless an OK read occurs.
- Bit counting: a 6-bit counter is loaded per phase and counts down. The phase ends at 0. All bit widths are exact, with no off-by-one turnaround.
- Command back-to-back: the earliest acceptance of the next command is the cycle after rsp_valid.

Decomposition:
- swd_host_pkg: state enum, ACK_OK/ACK_WAIT/ACK_FAULT constants, and phase-length constants (REQ_BITS=8, ACK_BITS=3, DATA_BITS=33).
- Sub-module swd_host_clkgen: CLK_DIV counter that produces swclk plus single-cycle rise_stb/fall_stb. It is enabled by the FSM busy signal and held low when idle.

Test Plan:
- Read DPIDR:
  - Stimulus: apndp=0, rnw=1, addr=0. Target model answers ACK 001 and data 0xDEADBEEF with parity 0.
  - Required response: the request byte on the wire is 0xA5 (LSB first). rsp_ack=001, rsp_rdata=0xDEADBEEF, rsp_perr=0.
  - Required timing: oe=0 from TRN1 through TRN2.
- Write ABORT:
  - Stimulus: apndp=0, rnw=0, addr=0, wdata=0x0000001E.
  - Required response: request byte 0x81, ACK OK, then 0x1E sent LSB first with parity 0. rsp_ack=001.
  - Required timing: total 8+1+3+1+33+IDLE_BITS = 48 swclk periods.
- WAIT ACK:
  - Stimulus: target answers 010 to an AP read.
  - Required response: no data phase, rsp_ack=010, rsp_rdata=0.
  - Required timing: 13+IDLE_BITS swclk periods.
- Parity error:
  - Stimulus: target returns 0x00000001 with parity 0.
  - Required response: rsp_perr=1 and rsp_rdata=0x00000001.
- Line reset:
  - Stimulus: raw command with nbits=49, wdata=0xFFFFFFFF.
  - Required response: 50 high bits with oe=1, then rsp_valid with rsp_ack=0.
- Reset mid-transfer:
  - Stimulus: assert rst during RDATA bit 10.
  - Required response: the next cycle shows swclk=0, oe=0, o=1 and no rsp_valid. cmd_ready=1 the cycle after rst deasserts.
  - Follow-up: a new DPIDR read completes correctly.

Source files
------------

// File: rtl/swd_host_pkg.sv
// Shared types and constants for the SWD host engine.
package swd_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_TRN1,
    ST_ACK,
    ST_RDATA,
    ST_TRN2,
    ST_WTRN,
    ST_WDATA,
    ST_TAIL,
    ST_RAW
  } state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int unsigned REQ_BITS  = 8;
  localparam int unsigned ACK_BITS  = 3;
  localparam int unsigned DATA_BITS = 33;
  localparam int unsigned CNT_W     = 6;

  // Request header, bit0 goes on the wire first: start, APnDP, RnW, A2, A3, parity, stop, park.
  function automatic logic [7:0] req_byte(input logic apndp, input logic rnw,
                                          input logic [1:0] addr);
    return {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

endpackage

// File: rtl/swd_host_clkgen.sv
// swclk generator: toggles every CLK_DIV clk cycles while enabled, idles low.
module swd_host_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic swclk,
  output logic rise_stb_c,
  output logic fall_stb_c
);

  localparam int unsigned DIV_W = 8;

  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;

  assign tick_c     = en && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_stb_c = tick_c && !swclk;
  assign fall_stb_c = tick_c && swclk;

  // Divider counter and swclk register; cleared whenever the engine is idle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      swclk   <= 1'b0;
    end else if (tick_c) begin
      div_cnt <= '0;
      swclk   <= ~swclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/swd_host_engine.sv
// SWD initiator: serialises one DP/AP transfer or raw bit sequence per command.
module swd_host_engine
  import swd_host_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned IDLE_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_raw,
  input  logic        cmd_apndp,
  input  logic        cmd_rnw,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [5:0]  cmd_nbits,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        swclk,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic        swdio_i
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       ack_q, ack_d;
  logic             rnw_q, rnw_d;
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic             cmd_ready_d, rsp_valid_d, rsp_perr_d, o_d, oe_d;
  logic [2:0]       rsp_ack_d;
  logic [31:0]      rsp_rdata_d;
  logic             rise_c, fall_c;

  swd_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q != ST_IDLE),
    .swclk      (swclk),
    .rise_stb_c (rise_c),
    .fall_stb_c (fall_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      rnw_q     <= 1'b0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_ack   <= '0;
      rsp_rdata <= '0;
      rsp_perr  <= 1'b0;
      swdio_o   <= 1'b1;
      swdio_oe  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      rnw_q     <= rnw_d;
      par_q     <= par_d;
      perr_q    <= perr_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_ack   <= rsp_ack_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_perr  <= rsp_perr_d;
      swdio_o   <= o_d;
      swdio_oe  <= oe_d;
    end
  end

  // Next-state logic: line changes on falling edges, samples on rising edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;
    rnw_d       = rnw_q;
    par_d       = par_q;
    perr_d      = perr_q;
    rsp_valid_d = 1'b0;
    rsp_ack_d   = rsp_ack;
    rsp_rdata_d = rsp_rdata;
    rsp_perr_d  = rsp_perr;
    o_d         = swdio_o;
    oe_d        = swdio_oe;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wdata_d = cmd_wdata;
          rnw_d   = cmd_rnw;
          ack_d   = '0;
          rdata_d = '0;
          perr_d  = 1'b0;
          oe_d    = 1'b1;
          if (cmd_raw) begin
            state_d = ST_RAW;
            sh_d    = cmd_wdata;
            cnt_d   = cmd_nbits;
            o_d     = cmd_wdata[0];
          end else begin
            state_d = ST_REQ;
            sh_d    = {24'b0, req_byte(cmd_apndp, cmd_rnw, cmd_addr)};
            cnt_d   = CNT_W'(REQ_BITS - 1);
            o_d     = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d = ST_TRN1;
            oe_d    = 1'b0;
            o_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            sh_d  = sh_q >> 1;
            o_d   = sh_q[1];
          end
        end
      end
      ST_TRN1: begin
        if (fall_c) begin
          state_d = ST_ACK;
          cnt_d   = CNT_W'(ACK_BITS - 1);
        end
      end
      ST_ACK: begin
        if (rise_c) ack_d = {swdio_i, ack_q[2:1]};
        if (fall_c) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (ack_q == ACK_OK && rnw_q) begin
            state_d = ST_RDATA;
            cnt_d   = CNT_W'(DATA_BITS - 1);
          end else if (ack_q == ACK_OK) begin
            state_d = ST_WTRN;
          end else begin
            state_d = ST_TRN2;
          end
        end
      end
      ST_RDATA: begin
        if (rise_c) begin
          if (cnt_q != '0) sh_d = {swdio_i, sh_q[31:1]};
          else             par_d = swdio_i;
        end
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d = ST_TRN2;
            rdata_d = sh_q;
            perr_d  = (^sh_q) != par_q;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_TRN2: begin
        if (fall_c) begin
          state_d = ST_TAIL;
          cnt_d   = CNT_W'(IDLE_BITS - 1);
          oe_d    = 1'b1;
          o_d     = 1'b0;
        end
      end
      ST_WTRN: begin
        if (fall_c) begin
          state_d = ST_WDATA;
          cnt_d   = CNT_W'(DATA_BITS - 1);
          sh_d    = wdata_q;
          oe_d    = 1'b1;
          o_d     = wdata_q[0];
        end
      end
      ST_WDATA: begin
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d = ST_TAIL;
            cnt_d   = CNT_W'(IDLE_BITS - 1);
            o_d     = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
            sh_d  = sh_q >> 1;
            o_d   = (cnt_q == CNT_W'(1)) ? ^wdata_q : sh_q[1];
          end
        end
      end
      ST_TAIL: begin
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_ack_d   = ack_q;
            rsp_rdata_d = rdata_q;
            rsp_perr_d  = perr_q;
            oe_d        = 1'b0;
            o_d         = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_RAW: begin
        // Arithmetic shift so bits beyond 31 repeat the top data bit.
        if (fall_c) begin
          if (cnt_q == '0) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_ack_d   = '0;
            rsp_rdata_d = '0;
            rsp_perr_d  = 1'b0;
            oe_d        = 1'b0;
            o_d         = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
            sh_d  = {sh_q[31], sh_q[31:1]};
            o_d   = sh_q[1];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
  end

endmodule

// File: tb/tb_swd_host_engine.sv
// Scoreboard bench for swd_host_engine with a simple SW-DP target model.
module tb_swd_host_engine;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned IDLE_BITS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_raw = 1'b0, cmd_apndp = 1'b0, cmd_rnw = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [5:0]  cmd_nbits = '0;
  logic        rsp_valid, rsp_perr, swclk, swdio_o, swdio_oe, swdio_i;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  swd_host_engine #(.CLK_DIV(CLK_DIV), .IDLE_BITS(IDLE_BITS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_raw(cmd_raw),
    .cmd_apndp(cmd_apndp), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_nbits(cmd_nbits),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .swclk(swclk), .swdio_o(swdio_o), .swdio_oe(swdio_oe), .swdio_i(swdio_i)
  );

  // kind: 0 = OK read, 1 = OK write, 2 = no data phase, 3 = raw sequence
  typedef struct {
    int          kind;
    logic [7:0]  req;
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
    logic [31:0] wdata;
    int          periods;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, rsp_cnt = 0;

  logic [2:0]  tgt_ack = '0;
  logic [31:0] tgt_data = '0;
  logic        tgt_par = 1'b0, tgt_rd = 1'b0;
  int          tgt_k = 0;
  logic        log_o [64];
  logic        log_oe[64];
  int          bit_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [7:0] req, input logic [2:0] ack,
                              input logic [31:0] rdata, input logic perr,
                              input logic [31:0] wdata, input int periods);
    exp_t e;
    e.kind = kind; e.req = req; e.ack = ack; e.rdata = rdata;
    e.perr = perr; e.wdata = wdata; e.periods = periods;
    return e;
  endfunction

  // Target: bit index advances on each swclk falling edge.
  initial forever begin
    @(negedge swclk);
    tgt_k = tgt_k + 1;
  end

  always_comb begin
    swdio_i = 1'b1;
    if (tgt_k >= 9 && tgt_k <= 11)
      swdio_i = tgt_ack[2'(tgt_k - 9)];
    else if (tgt_rd && tgt_ack == 3'b001 && tgt_k >= 12 && tgt_k <= 43)
      swdio_i = tgt_data[5'(tgt_k - 12)];
    else if (tgt_rd && tgt_ack == 3'b001 && tgt_k == 44)
      swdio_i = tgt_par;
  end

  // Wire log: host line state at each swclk rising edge.
  initial forever begin
    @(posedge swclk);
    #1;
    if (bit_n < 64) begin
      log_o[bit_n]  = swdio_o;
      log_oe[bit_n] = swdio_oe;
    end
    bit_n = bit_n + 1;
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        int bad;
        logic [7:0]  r;
        logic [31:0] w;
        e = exp_q.pop_front();
        chk("rsp_ack", 64'(rsp_ack), 64'(e.ack));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_perr", 64'(rsp_perr), 64'(e.perr));
        chk("periods", 64'(bit_n), 64'(e.periods));
        chk("ready_low_on_rsp", 64'(cmd_ready), 64'd0);
        if (e.kind == 3) begin
          bad = 0;
          for (int i = 0; i < e.periods; i++)
            if (!log_oe[i] || log_o[i] !== e.wdata[(i > 31) ? 31 : i]) bad++;
          chk("raw_bits", 64'(bad), 64'd0);
        end else begin
          bad = 0;
          for (int i = 0; i < 8; i++) begin
            r[i] = log_o[i];
            if (!log_oe[i]) bad++;
          end
          chk("req_byte", 64'(r), 64'(e.req));
          chk("req_oe", 64'(bad), 64'd0);
          bad = 0;
          for (int i = 8; i <= ((e.kind == 0) ? 45 : 12); i++)
            if (log_oe[i]) bad++;
          chk("released", 64'(bad), 64'd0);
          if (e.kind == 1) begin
            bad = 0;
            for (int i = 0; i < 32; i++) begin
              w[i] = log_o[13 + i];
              if (!log_oe[13 + i]) bad++;
            end
            if (!log_oe[45]) bad++;
            chk("wdata", 64'(w), 64'(e.wdata));
            chk("wpar", 64'(log_o[45]), 64'(^e.wdata));
            chk("wdata_oe", 64'(bad), 64'd0);
          end
          bad = 0;
          for (int i = e.periods - int'(IDLE_BITS); i < e.periods; i++)
            if (!log_oe[i] || log_o[i] !== 1'b0) bad++;
          chk("tail", 64'(bad), 64'd0);
        end
      end
      rsp_cnt = rsp_cnt + 1;
    end
  end

  task automatic issue(input logic raw, input logic apndp, input logic rnw,
                       input logic [1:0] addr, input logic [31:0] wd, input logic [5:0] nb,
                       input logic [2:0] t_ack, input logic [31:0] t_data, input logic t_par,
                       input logic expect_rsp, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
    tgt_ack = t_ack; tgt_data = t_data; tgt_par = t_par; tgt_rd = rnw && !raw;
    tgt_k = 0; bit_n = 0;
    if (expect_rsp) exp_q.push_back(e);
    cmd_raw = raw; cmd_apndp = apndp; cmd_rnw = rnw; cmd_addr = addr;
    cmd_wdata = wd; cmd_nbits = nb; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int start = rsp_cnt;
    int n = 0;
    while (rsp_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 64'(rsp_cnt != start), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    int n;
    none = mk(0, 8'h00, 3'b000, 32'h0, 1'b0, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_ack", 64'(rsp_ack), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_perr", 64'(rsp_perr), 64'd0);
    chk("rst_swclk", 64'(swclk), 64'd0);
    chk("rst_swdio_o", 64'(swdio_o), 64'd1);
    chk("rst_swdio_oe", 64'(swdio_oe), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read DPIDR
    issue(0, 0, 1, 2'd0, 32'h0, 6'd0, 3'b001, 32'hDEADBEEF, 1'b0, 1,
          mk(0, 8'hA5, 3'b001, 32'hDEADBEEF, 1'b0, 32'h0, 48));
    wait_rsp();
    // Write ABORT
    issue(0, 0, 0, 2'd0, 32'h0000001E, 6'd0, 3'b001, 32'h0, 1'b0, 1,
          mk(1, 8'h81, 3'b001, 32'h0, 1'b0, 32'h0000001E, 48));
    wait_rsp();
    // WAIT on AP read
    issue(0, 1, 1, 2'd0, 32'h0, 6'd0, 3'b010, 32'hFFFFFFFF, 1'b1, 1,
          mk(2, 8'h87, 3'b010, 32'h0, 1'b0, 32'h0, 15));
    wait_rsp();
    // Parity error
    issue(0, 0, 1, 2'd0, 32'h0, 6'd0, 3'b001, 32'h00000001, 1'b0, 1,
          mk(0, 8'hA5, 3'b001, 32'h00000001, 1'b1, 32'h0, 48));
    wait_rsp();
    // AP read at 0xC, odd-parity data
    issue(0, 1, 1, 2'd3, 32'h0, 6'd0, 3'b001, 32'h12345678, 1'b1, 1,
          mk(0, 8'h9F, 3'b001, 32'h12345678, 1'b0, 32'h0, 48));
    wait_rsp();
    // FAULT on AP write
    issue(0, 1, 0, 2'd1, 32'hCAFEF00D, 6'd0, 3'b100, 32'h0, 1'b0, 1,
          mk(2, 8'h8B, 3'b100, 32'h0, 1'b0, 32'h0, 15));
    wait_rsp();
    // Line reset, 50 ones
    issue(1, 0, 0, 2'd0, 32'hFFFFFFFF, 6'd49, 3'b000, 32'h0, 1'b0, 1,
          mk(3, 8'h00, 3'b000, 32'h0, 1'b0, 32'hFFFFFFFF, 50));
    wait_rsp();
    // JTAG-to-SWD select, 16 bits
    issue(1, 0, 0, 2'd0, 32'h0000E79E, 6'd15, 3'b000, 32'h0, 1'b0, 1,
          mk(3, 8'h00, 3'b000, 32'h0, 1'b0, 32'h0000E79E, 16));
    wait_rsp();
    // 40 bits: bits 31..39 all repeat wdata[31]
    issue(1, 0, 0, 2'd0, 32'h80000000, 6'd39, 3'b000, 32'h0, 1'b0, 1,
          mk(3, 8'h00, 3'b000, 32'h0, 1'b0, 32'h80000000, 40));
    wait_rsp();
    // Single raw bit
    issue(1, 0, 0, 2'd0, 32'h00000001, 6'd0, 3'b000, 32'h0, 1'b0, 1,
          mk(3, 8'h00, 3'b000, 32'h0, 1'b0, 32'h00000001, 1));
    wait_rsp();

    // Reset during RDATA bit 10 (wire bit 22)
    issue(0, 0, 1, 2'd0, 32'h0, 6'd0, 3'b001, 32'hDEADBEEF, 1'b0, 0, none);
    n = 0;
    while (tgt_k < 22 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rdata_bit10", 64'(tgt_k >= 22), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_swclk", 64'(swclk), 64'd0);
    chk("midrst_oe", 64'(swdio_oe), 64'd0);
    chk("midrst_o", 64'(swdio_o), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ready", 64'(cmd_ready), 64'd1);

    // Follow-up DPIDR read
    issue(0, 0, 1, 2'd0, 32'h0, 6'd0, 3'b001, 32'hDEADBEEF, 1'b0, 1,
          mk(0, 8'hA5, 3'b001, 32'hDEADBEEF, 1'b0, 32'h0, 48));
    wait_rsp();

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
